// File: rtl/flush_eaten_food_unit_pkg.sv
// Shared maze geometry constants and the food bitmap row type.
package flush_eaten_food_unit_pkg;

  localparam int MAZE_COLS       = 80;
  localparam int MAZE_ROWS       = 60;
  localparam int CELL_SIZE       = 16;
  localparam int CELL_SHIFT      = 4;
  localparam int H_VISIBLE_START = 0;
  localparam int V_VISIBLE_START = 0;

  typedef logic [MAZE_COLS-1:0] food_row_t;

  // Row with food in columns 0..cols-1 and nothing above.
  function automatic food_row_t full_row(input int cols);
    food_row_t r;
    for (int i = 0; i < MAZE_COLS; i++) r[i] = (i < cols);
    return r;
  endfunction

endpackage

// File: rtl/flush_eaten_food_unit_if.sv
// Pac-Man position in, renderer row-read port and eaten pulse out.
interface flush_eaten_food_unit_if;
  import flush_eaten_food_unit_pkg::*;

  logic [10:0] pacman_curr_pos_x;
  logic [9:0]  pacman_curr_pos_y;
  logic [5:0]  food_map_read_y;
  food_row_t   food_row;
  logic        is_food;

  modport master (
    output pacman_curr_pos_x, pacman_curr_pos_y, food_map_read_y,
    input  food_row, is_food
  );

  modport slave (
    input  pacman_curr_pos_x, pacman_curr_pos_y, food_map_read_y,
    output food_row, is_food
  );
endinterface

// File: rtl/flush_eaten_food_unit_tick_gen.sv
// Modulo-DIV counter producing a one-cycle clock enable; stands in for a divided clock.
module tick_gen #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  import flush_eaten_food_unit_pkg::*;

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                count <= '0;
    else if (count == LAST) count <= '0;
    else                    count <= count + 1'b1;
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/flush_eaten_food_unit.sv
// Food bitmap: clears the cell under Pac-Man on each update tick and serves rows to the renderer.
module flush_eaten_food_unit #(
  parameter int SCALING_FACTOR  = flush_eaten_food_unit_pkg::CELL_SIZE,
  parameter int H_VISIBLE_START = flush_eaten_food_unit_pkg::H_VISIBLE_START,
  parameter int V_VISIBLE_START = flush_eaten_food_unit_pkg::V_VISIBLE_START,
  parameter int MOVE_TO_CENTER  = 0,
  parameter int COLS            = flush_eaten_food_unit_pkg::MAZE_COLS,
  parameter int ROWS            = flush_eaten_food_unit_pkg::MAZE_ROWS,
  parameter int DIV             = 2
) (
  input logic                    clk,
  input logic                    rst,
  flush_eaten_food_unit_if.slave bus
);
  import flush_eaten_food_unit_pkg::*;

  localparam int SHIFT = $clog2(SCALING_FACTOR);
  localparam int IW    = 13 - SHIFT;
  localparam food_row_t FULL = full_row(COLS);

  logic             tick;
  logic signed [12:0] dx, dy;
  logic [IW-1:0]    idx_x, idx_y;
  logic             pos_valid;
  logic [6:0]       cell_x;
  logic [5:0]       cell_y;
  food_row_t        map [64];

  tick_gen #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // 13-bit signed offsets so a position left of/above the origin stays negative instead of wrapping.
  assign dx = $signed({2'b00, bus.pacman_curr_pos_x}) - $signed(13'(H_VISIBLE_START + MOVE_TO_CENTER));
  assign dy = $signed({3'b000, bus.pacman_curr_pos_y}) - $signed(13'(V_VISIBLE_START + MOVE_TO_CENTER));
  assign idx_x = dx[12:SHIFT];
  assign idx_y = dy[12:SHIFT];
  assign pos_valid = !dx[12] && !dy[12] && (int'(idx_x) < COLS) && (int'(idx_y) < ROWS);
  assign cell_x = idx_x[6:0];
  assign cell_y = idx_y[5:0];

  // The read samples the map before this edge's clear lands, giving read-before-write on collisions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 64; r++) map[r] <= (r < ROWS) ? FULL : '0;
      bus.food_row <= '0;
      bus.is_food  <= 1'b0;
    end else begin
      bus.food_row <= (int'(bus.food_map_read_y) < ROWS) ? map[bus.food_map_read_y] : '0;
      if (tick && pos_valid) begin
        map[cell_y][cell_x] <= 1'b0;
        bus.is_food         <= map[cell_y][cell_x];
      end else begin
        bus.is_food <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_flush_eaten_food_unit.sv
// Scenario bench for flush_eaten_food_unit; a second instance with H_VISIBLE_START=16 covers underflow.
module tb_flush_eaten_food_unit;
  import flush_eaten_food_unit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  food_row_t model [64];
  food_row_t exp_q [$];

  flush_eaten_food_unit_if bus ();
  flush_eaten_food_unit_if bus_off ();

  flush_eaten_food_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  flush_eaten_food_unit #(.H_VISIBLE_START(16)) dut_off (
    .clk (clk),
    .rst (rst),
    .bus (bus_off)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int r = 0; r < 64; r++) model[r] = (r < 60) ? full_row(80) : '0;
  endtask

  // Pushes the expected row at drive time and pops it when the registered read appears.
  task automatic read_row(input int y, output food_row_t got, output food_row_t exp);
    exp_q.push_back(model[y]);
    bus.food_map_read_y = 6'(y);
    @(negedge clk);
    got = bus.food_row;
    exp = exp_q.pop_front();
  endtask

  task automatic set_pos(input int x, input int y);
    bus.pacman_curr_pos_x = 11'(x);
    bus.pacman_curr_pos_y = 10'(y);
  endtask

  task automatic watch_pulses(input int cycles, output int pulses, output int max_run,
                              output int pulses_off);
    int run;
    pulses = 0; max_run = 0; pulses_off = 0; run = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (bus.is_food === 1'b1) begin
        pulses++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      if (bus_off.is_food === 1'b1) pulses_off++;
    end
  endtask

  task automatic test_reset();
    food_row_t got, exp;
    int rows [4] = '{27, 59, 60, 63};
    @(negedge clk);
    checks++;
    if (bus.food_row !== '0) begin
      failures++; $display("[TB] FAIL reset food_row: got %h expected 0", bus.food_row);
    end
    checks++;
    if (bus.is_food !== 1'b0) begin
      failures++; $display("[TB] FAIL reset is_food: got %b expected 0", bus.is_food);
    end
    rst = 1'b0;
    model_reset();
    foreach (rows[i]) begin
      read_row(rows[i], got, exp);
      checks++;
      if (got !== exp) begin
        failures++; $display("[TB] FAIL reset read row %0d: got %h expected %h", rows[i], got, exp);
      end
    end
  endtask

  task automatic test_eat(input string name, input int x, input int y, input int cx, input int cy,
                          input int other_row);
    food_row_t got, exp;
    int pulses, max_run, pulses_off;
    set_pos(x, y);
    model[cy][cx] = 1'b0;
    watch_pulses(6, pulses, max_run, pulses_off);
    checks++;
    if (pulses !== 1) begin
      failures++; $display("[TB] FAIL %s pulse count: got %0d expected 1", name, pulses);
    end
    checks++;
    if (max_run !== 1) begin
      failures++; $display("[TB] FAIL %s pulse width: got %0d expected 1", name, max_run);
    end
    read_row(cy, got, exp);
    checks++;
    if (got !== exp) begin
      failures++; $display("[TB] FAIL %s row %0d: got %h expected %h", name, cy, got, exp);
    end
    read_row(other_row, got, exp);
    checks++;
    if (got !== exp) begin
      failures++; $display("[TB] FAIL %s row %0d: got %h expected %h", name, other_row, got, exp);
    end
  endtask

  task automatic test_hold();
    food_row_t got, exp;
    int pulses, max_run, pulses_off;
    watch_pulses(20, pulses, max_run, pulses_off);
    checks++;
    if (pulses !== 0) begin
      failures++; $display("[TB] FAIL hold pulse count: got %0d expected 0", pulses);
    end
    read_row(27, got, exp);
    checks++;
    if (got !== exp) begin
      failures++; $display("[TB] FAIL hold row 27: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_out_of_range();
    food_row_t got, exp;
    int pulses, max_run, pulses_off, off_total;
    int xs [2] = '{1300, 100};
    int ys [2] = '{432, 980};
    off_total = 0;
    foreach (xs[i]) begin
      set_pos(xs[i], ys[i]);
      watch_pulses(6, pulses, max_run, pulses_off);
      off_total += pulses_off;
      checks++;
      if (pulses !== 0) begin
        failures++; $display("[TB] FAIL oob (%0d,%0d) pulses: got %0d expected 0", xs[i], ys[i], pulses);
      end
      read_row(27, got, exp);
      checks++;
      if (got !== exp) begin
        failures++; $display("[TB] FAIL oob (%0d,%0d) row 27: got %h expected %h", xs[i], ys[i], got, exp);
      end
      read_row(61, got, exp);
      checks++;
      if (got !== exp) begin
        failures++; $display("[TB] FAIL oob (%0d,%0d) row 61: got %h expected %h", xs[i], ys[i], got, exp);
      end
    end
    checks++;
    if (off_total !== 0) begin
      failures++; $display("[TB] FAIL underflow pulses: got %0d expected 0", off_total);
    end
    checks++;
    if (bus_off.food_row !== full_row(80)) begin
      failures++; $display("[TB] FAIL underflow row 27: got %h expected %h", bus_off.food_row, full_row(80));
    end
  endtask

  task automatic test_collision();
    food_row_t pre, post;
    bit found;
    pre = model[23];
    model[23][30] = 1'b0;
    post = model[23];
    found = 1'b0;
    set_pos(480, 368);
    bus.food_map_read_y = 6'd23;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (bus.is_food === 1'b1) begin
        found = 1'b1;
        checks++;
        if (bus.food_row !== pre) begin
          failures++; $display("[TB] FAIL collision pre-clear row: got %h expected %h", bus.food_row, pre);
        end
        @(negedge clk);
        checks++;
        if (bus.food_row !== post) begin
          failures++; $display("[TB] FAIL collision post-clear row: got %h expected %h", bus.food_row, post);
        end
      end
    end
    if (!found) begin
      checks++; failures++;
      $display("[TB] FAIL collision timeout: got no is_food pulse expected one within 10 cycles");
    end
  endtask

  task automatic test_reset_mid_run();
    food_row_t got, exp;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.food_row !== '0) begin
      failures++; $display("[TB] FAIL midrun reset food_row: got %h expected 0", bus.food_row);
    end
    checks++;
    if (bus.is_food !== 1'b0) begin
      failures++; $display("[TB] FAIL midrun reset is_food: got %b expected 0", bus.is_food);
    end
    set_pos(1300, 980);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    read_row(23, got, exp);
    checks++;
    if (got !== exp) begin
      failures++; $display("[TB] FAIL midrun reset row 23: got %h expected %h", got, exp);
    end
    read_row(27, got, exp);
    checks++;
    if (got !== exp) begin
      failures++; $display("[TB] FAIL midrun reset row 27: got %h expected %h", got, exp);
    end
  endtask

  initial begin
    set_pos(1300, 980);
    bus.food_map_read_y = 6'd0;
    bus_off.pacman_curr_pos_x = 11'd5;
    bus_off.pacman_curr_pos_y = 10'd432;
    bus_off.food_map_read_y = 6'd27;
    test_reset();
    test_eat("eat (608,432)", 608, 432, 38, 27, 26);
    test_hold();
    test_eat("eat (464,368)", 464, 368, 29, 23, 27);
    test_out_of_range();
    test_collision();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/flush_eaten_food_unit.md
Name: flush_eaten_food_unit

Overview:
- Tracks which maze cells still hold food and removes food from the cell Pac-Man currently occupies.
- Holds an 80x60 food bitmap, one bit per 16x16-pixel cell.
- Converts Pac-Man's pixel position to a cell index and clears that bit.
- Exposes a synchronous row-read port for the renderer, plus a one-cycle "food eaten" pulse for scoring.

Parameters:
- SCALING_FACTOR, 16: pixels per cell; must be a power of two (index = offset >> log2).
- H_VISIBLE_START, 0: pixel x of cell column 0.
- V_VISIBLE_START, 0: pixel y of cell row 0.
- MOVE_TO_CENTER, 0: pixel offset within a cell at which a sprite position is reported; subtracted before the divide.
- COLS, 80: cells per row (≤ 80, the row width).
- ROWS, 60: valid rows (≤ 64).
- DIV, 2: update-tick period in clk cycles (≥ 1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- pacman_curr_pos_x  in  11  Pac-Man pixel x.
- pacman_curr_pos_y  in  10  Pac-Man pixel y.
- food_map_read_y  in  6  row address for the read port.
- food_row  out  80  bitmap row; bit i = column i; 1 = food present.
- is_food  out  1  one-cycle pulse: food was just removed at Pac-Man's cell.

Behaviour:
- Single clock domain. No second or derived clock. The update rate is set by an internal clock-enable tick.
- Reset (asynchronous, active-high):
  - Rows 0..ROWS-1: bits 0..COLS-1 set to 1; higher bits 0.
  - Tick counter = 0.
  - food_row = 0, is_food = 0.
- Tick generation:
  - Counter counts 0..DIV-1 and wraps.
  - tick = 1 in the cycle where counter == DIV-1.
  - First tick is at the DIV-th rising edge after reset deasserts.
- Index computation (combinational):
  - dx = pos_x − H_VISIBLE_START − MOVE_TO_CENTER; dy likewise with V_VISIBLE_START.
  - idx_x = dx >> log2(SCALING_FACTOR); idx_y = dy >> log2(SCALING_FACTOR).
  - Position is valid only if dx ≥ 0, dy ≥ 0, idx_x < COLS and idx_y < ROWS. Use a signed or extra-bit compare; an underflow must not wrap into a valid index.
- Clear (on a tick edge, with a valid position):
  - map[idx_y][idx_x] <= 0.
  - is_food <= old bit value, so it pulses only when food was actually present.
  - On a non-tick edge or with an invalid position: is_food <= 0 and the map is unchanged.
- Eating latency: the bit clears at the tick edge; is_food is high for exactly one clk cycle after that edge.
- Standing still after eating: no further pulses (bit is already 0).
- Read port:
  - food_row <= map[food_map_read_y] every edge, one-cycle latency.
  - Address ≥ ROWS returns all zeros.
- Read/clear collision (same row, same edge): food_row returns the pre-clear value (read-before-write). The cleared value appears on the next read.
- Bitmap is only ever cleared; it is refilled only by reset.
- Reset asserted mid-operation immediately restores the full map and zeroes the outputs.

Decomposition:
- Shared package (maze_pkg):
  - Constants MAZE_COLS=80, MAZE_ROWS=60, CELL_SIZE=16, CELL_SHIFT=4, H_VISIBLE_START, V_VISIBLE_START.
  - Typedef food_row_t (logic [79:0]).
- One natural sub-module: tick_gen.
  - Parameter DIV; ports clk, rst, tick.
  - Modulo-DIV counter that emits a single-cycle enable.
  - Replaces any divided clock.

Test Plan:
- Reset, then read rows 27 and 59 → food_row = all-ones (80'hFFFF_FFFF_FFFF_FFFF_FFFF); read row 60 and row 63 → 0.
- Position (608,432) [cell 38,27]; read row 27 → within 3 clk, food_row = all-ones with bit 38 = 0. is_food pulses exactly once, one cycle wide.
- Hold (608,432) for 20 cycles → is_food stays 0 and row 27 is unchanged.
- Move to (464,368) [cell 29,23] → row 23 bit 29 = 0, one is_food pulse; row 27 still has only bit 38 cleared.
- Out-of-range positions → no map change, is_food = 0, for each of:
  - x = 1300 (idx 81);
  - y = 980 (idx 61);
  - x = 5 with H_VISIBLE_START = 16 (underflow).
- Collision: read row 23 while clearing (480,368) [cell 30,23] → first food_row shows bit 30 = 1, next cycle shows bit 30 = 0. Then assert rst mid-run → all rows return to all-ones and is_food = 0 immediately.
